// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and constants for the decode-stage LMUL sequencer.
package riscv_v_pkg;

  // vl spans 0..128 inclusive (16 elements x 8 registers), so it needs one bit beyond clog2(128)
  localparam int unsigned VL_W             = 8;
  localparam int unsigned NREG_B           = 16;
  localparam int unsigned RISCV_V_MAX_LMUL = 8;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned N_W     = 4;
  localparam int unsigned EBASE_W = 7;
  localparam int unsigned ECNT_W  = 5;
  localparam int unsigned SEW_W   = 3;
  localparam int unsigned LMUL_W  = 3;

  // vtype = {vill, vma, vta, vsew[2:0], vlmul[2:0]}
  localparam int unsigned VTYPE_W         = 9;
  localparam int unsigned VTYPE_VLMUL_LSB = 0;
  localparam int unsigned VTYPE_VSEW_LSB  = 3;
  localparam int unsigned VTYPE_VTA_BIT   = 6;
  localparam int unsigned VTYPE_VMA_BIT   = 7;
  localparam int unsigned VTYPE_VILL_BIT  = 8;

  localparam logic [LMUL_W-1:0] VLMUL_1    = 3'b000;
  localparam logic [LMUL_W-1:0] VLMUL_2    = 3'b001;
  localparam logic [LMUL_W-1:0] VLMUL_4    = 3'b010;
  localparam logic [LMUL_W-1:0] VLMUL_8    = 3'b011;
  localparam logic [LMUL_W-1:0] VLMUL_RSVD = 3'b100;
  localparam logic [LMUL_W-1:0] VLMUL_F8   = 3'b101;
  localparam logic [LMUL_W-1:0] VLMUL_F4   = 3'b110;
  localparam logic [LMUL_W-1:0] VLMUL_F2   = 3'b111;

  localparam logic [SEW_W-1:0] VSEW_8  = 3'd0;
  localparam logic [SEW_W-1:0] VSEW_16 = 3'd1;
  localparam logic [SEW_W-1:0] VSEW_32 = 3'd2;
  localparam logic [SEW_W-1:0] VSEW_64 = 3'd3;

  typedef struct packed {
    logic               first;
    logic               last;
    logic [IDX_W-1:0]   idx;
    logic [EBASE_W-1:0] elem_base;
    logic [ECNT_W-1:0]  elem_cnt;
  } uop_info_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/riscv_v_lmul_decode.sv
// Combinational vtype / vl / register-alignment decode for the LMUL sequencer.
module riscv_v_lmul_decode
  import riscv_v_pkg::*;
(
  input  logic              i_vill,
  input  logic [SEW_W-1:0]  i_vsew,
  input  logic [LMUL_W-1:0] i_vlmul,
  input  logic [VL_W-1:0]   i_vl,
  input  logic              i_is_vv,
  input  logic [REG_W-1:0]  i_vs1,
  input  logic [REG_W-1:0]  i_vs2,
  input  logic [REG_W-1:0]  i_vd,
  output logic [N_W-1:0]    o_n,
  output logic [1:0]        o_epr_shift,
  output logic              o_illegal
);

  logic [N_W-1:0]    w_lmul;
  logic [2:0]        w_mask;
  logic              w_misalign;
  logic [ECNT_W-1:0] w_epr;
  logic [2:0]        w_log_epr;
  logic [8:0]        w_groups;

  // Group size, alignment, legality and micro-op count
  always_comb begin
    w_lmul = 4'd1;
    case (i_vlmul)
      VLMUL_1: w_lmul = 4'd1;
      VLMUL_2: w_lmul = 4'd2;
      VLMUL_4: w_lmul = 4'd4;
      VLMUL_8: w_lmul = 4'd8;
      default: w_lmul = 4'd1;
    endcase

    w_mask     = 3'(w_lmul - 4'd1);
    w_misalign = (|(i_vd[2:0] & w_mask)) | (|(i_vs2[2:0] & w_mask)) |
                 (i_is_vv & (|(i_vs1[2:0] & w_mask)));
    o_illegal  = i_vill | (i_vsew > VSEW_64) | (i_vlmul == VLMUL_RSVD) | w_misalign;

    // Only the low two vsew bits matter once illegal widths are rejected
    o_epr_shift = i_vsew[1:0];
    w_epr       = ECNT_W'(NREG_B >> o_epr_shift);
    w_log_epr   = 3'd4 - {1'b0, o_epr_shift};
    w_groups    = (9'(i_vl) + 9'(w_epr) - 9'd1) >> w_log_epr;

    if (i_vl == '0) begin
      o_n = 4'd1;
    end else if (w_groups < 9'(w_lmul)) begin
      o_n = N_W'(w_groups);
    end else begin
      o_n = w_lmul;
    end
  end

endmodule

// File: rtl/riscv_v_lmul_seq.sv
// Splits an LMUL>1 vector instruction in ID into per-register micro-ops.
module riscv_v_lmul_seq
  import riscv_v_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_instr_valid_id,
  input  logic               i_is_vv_id,
  input  logic [REG_W-1:0]   i_vs1_id,
  input  logic [REG_W-1:0]   i_vs2_id,
  input  logic [REG_W-1:0]   i_vd_id,
  input  logic [VTYPE_W-1:0] i_vtype,
  input  logic [VL_W-1:0]    i_vl,
  input  logic               i_riscv_stall,
  input  logic               i_flush,
  output logic               o_seq_stall,
  output logic               o_uop_valid,
  output logic               o_uop_first,
  output logic               o_uop_last,
  output logic [IDX_W-1:0]   o_uop_idx,
  output logic [REG_W-1:0]   o_vs1_uop,
  output logic [REG_W-1:0]   o_vs2_uop,
  output logic [REG_W-1:0]   o_vd_uop,
  output logic [EBASE_W-1:0] o_elem_base,
  output logic [ECNT_W-1:0]  o_elem_cnt,
  output logic               o_illegal
);

  seq_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              w_latch;

  logic [N_W-1:0]    r_n;
  logic [REG_W-1:0]  r_vs1, r_vs2, r_vd;
  logic              r_is_vv;
  logic [SEW_W-1:0]  r_vsew;
  logic [LMUL_W-1:0] r_vlmul;
  logic [VL_W-1:0]   r_vl;

  logic              w_in_seq;
  logic              w_vill;
  logic [SEW_W-1:0]  w_vsew;
  logic [LMUL_W-1:0] w_vlmul;
  logic [VL_W-1:0]   w_vl;
  logic              w_is_vv;
  logic [REG_W-1:0]  w_vs1, w_vs2, w_vd;
  logic [IDX_W-1:0]  w_k;

  logic [N_W-1:0]    w_dec_n;
  logic [1:0]        w_epr_shift;
  logic              w_dec_illegal;

  logic [EBASE_W-1:0] w_elem_base;
  logic [ECNT_W-1:0]  w_epr;
  logic [ECNT_W-1:0]  w_elem_cnt;
  logic [VL_W-1:0]    w_rem;

  uop_info_t         w_info;
  logic              w_uop_valid;
  logic              w_seq_stall;
  logic              w_illegal;
  logic [REG_W-1:0]  w_vs1_uop, w_vs2_uop, w_vd_uop;

  // Tail policy bits only matter to the datapath
  logic w_unused_vtype;
  assign w_unused_vtype = ^i_vtype[VTYPE_VMA_BIT:VTYPE_VTA_BIT];

  // In SEQ the group runs from latched fields so CSR/ID changes cannot disturb it
  assign w_in_seq = (r_state == ST_SEQ);
  assign w_vill   = w_in_seq ? 1'b0    : i_vtype[VTYPE_VILL_BIT];
  assign w_vsew   = w_in_seq ? r_vsew  : i_vtype[VTYPE_VSEW_LSB +: SEW_W];
  assign w_vlmul  = w_in_seq ? r_vlmul : i_vtype[VTYPE_VLMUL_LSB +: LMUL_W];
  assign w_vl     = w_in_seq ? r_vl    : i_vl;
  assign w_is_vv  = w_in_seq ? r_is_vv : i_is_vv_id;
  assign w_vs1    = w_in_seq ? r_vs1   : i_vs1_id;
  assign w_vs2    = w_in_seq ? r_vs2   : i_vs2_id;
  assign w_vd     = w_in_seq ? r_vd    : i_vd_id;
  assign w_k      = w_in_seq ? r_idx   : '0;

  riscv_v_lmul_decode u_decode (
    .i_vill      (w_vill),
    .i_vsew      (w_vsew),
    .i_vlmul     (w_vlmul),
    .i_vl        (w_vl),
    .i_is_vv     (w_is_vv),
    .i_vs1       (w_vs1),
    .i_vs2       (w_vs2),
    .i_vd        (w_vd),
    .o_n         (w_dec_n),
    .o_epr_shift (w_epr_shift),
    .o_illegal   (w_dec_illegal)
  );

  // Element window of micro-op k, with the count saturating at zero past vl
  always_comb begin
    w_elem_base = EBASE_W'({4'b0000, w_k} << (3'd4 - {1'b0, w_epr_shift}));
    w_epr       = ECNT_W'(NREG_B >> w_epr_shift);
    w_rem       = w_vl - VL_W'(w_elem_base);
    w_elem_cnt  = '0;
    if (w_vl > VL_W'(w_elem_base)) begin
      w_elem_cnt = (w_rem > VL_W'(w_epr)) ? w_epr : ECNT_W'(w_rem);
    end
  end

  // Next-state, sequencing control and micro-op outputs
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_info      = '0;
    w_uop_valid = 1'b0;
    w_seq_stall = 1'b0;
    w_illegal   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_illegal   = i_instr_valid_id & w_dec_illegal;
        w_uop_valid = i_instr_valid_id & ~w_dec_illegal;
        if (w_uop_valid) begin
          w_info.first = 1'b1;
          w_info.last  = (w_dec_n == 4'd1);
          w_seq_stall  = (w_dec_n != 4'd1);
        end
        if (w_seq_stall && !i_riscv_stall && !i_flush) begin
          w_latch     = 1'b1;
          w_idx_nxt   = 3'd1;
          w_state_nxt = ST_SEQ;
        end
      end
      ST_SEQ: begin
        w_uop_valid = 1'b1;
        w_info.last = ({1'b0, r_idx} == (r_n - 4'd1));
        w_seq_stall = ~w_info.last;
        if (i_flush) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (!i_riscv_stall) begin
          if (w_info.last) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_vs1_uop = '0;
    w_vs2_uop = '0;
    w_vd_uop  = '0;
    if (w_uop_valid) begin
      w_info.idx       = w_k;
      w_info.elem_base = w_elem_base;
      w_info.elem_cnt  = w_elem_cnt;
      w_vd_uop         = w_vd  | REG_W'(w_k);
      w_vs2_uop        = w_vs2 | REG_W'(w_k);
      w_vs1_uop        = w_is_vv ? (w_vs1 | REG_W'(w_k)) : w_vs1;
    end
  end

  assign o_seq_stall = w_seq_stall;
  assign o_uop_valid = w_uop_valid;
  assign o_uop_first = w_info.first;
  assign o_uop_last  = w_info.last;
  assign o_uop_idx   = w_info.idx;
  assign o_elem_base = w_info.elem_base;
  assign o_elem_cnt  = w_info.elem_cnt;
  assign o_vs1_uop   = w_vs1_uop;
  assign o_vs2_uop   = w_vs2_uop;
  assign o_vd_uop    = w_vd_uop;
  assign o_illegal   = w_illegal;

  // FSM state and micro-op index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Capture the ID instruction and CSR view when a multi-uop group starts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n     <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vd    <= '0;
      r_is_vv <= 1'b0;
      r_vsew  <= '0;
      r_vlmul <= '0;
      r_vl    <= '0;
    end else if (w_latch) begin
      r_n     <= w_dec_n;
      r_vs1   <= i_vs1_id;
      r_vs2   <= i_vs2_id;
      r_vd    <= i_vd_id;
      r_is_vv <= i_is_vv_id;
      r_vsew  <= i_vtype[VTYPE_VSEW_LSB +: SEW_W];
      r_vlmul <= i_vtype[VTYPE_VLMUL_LSB +: LMUL_W];
      r_vl    <= i_vl;
    end
  end

endmodule

// File: tb/tb_riscv_v_lmul_seq.sv
// Self-checking bench for riscv_v_lmul_seq against an arithmetic group model.
module tb_riscv_v_lmul_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, is_vv, rstall, flush;
  logic [4:0] vs1, vs2, vd;
  logic [8:0] vtype;
  logic [7:0] vl;

  logic       seq_stall, uop_valid, uop_first, uop_last, illegal;
  logic [2:0] uop_idx;
  logic [4:0] vs1_uop, vs2_uop, vd_uop;
  logic [6:0] elem_base;
  logic [4:0] elem_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the instruction currently in ID
  int m_vd, m_vs2, m_vs1, m_vl, m_lmul, m_epr, m_n;
  bit m_isvv, m_illegal;

  always #5 clk = ~clk;

  riscv_v_lmul_seq dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_instr_valid_id (valid),
    .i_is_vv_id       (is_vv),
    .i_vs1_id         (vs1),
    .i_vs2_id         (vs2),
    .i_vd_id          (vd),
    .i_vtype          (vtype),
    .i_vl             (vl),
    .i_riscv_stall    (rstall),
    .i_flush          (flush),
    .o_seq_stall      (seq_stall),
    .o_uop_valid      (uop_valid),
    .o_uop_first      (uop_first),
    .o_uop_last       (uop_last),
    .o_uop_idx        (uop_idx),
    .o_vs1_uop        (vs1_uop),
    .o_vs2_uop        (vs2_uop),
    .o_vd_uop         (vd_uop),
    .o_elem_base      (elem_base),
    .o_elem_cnt       (elem_cnt),
    .o_illegal        (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_reg(input int lm);
    int r;
    r = $urandom_range(31);
    if ($urandom_range(9) != 0) r = r - (r % lm);
    return r;
  endfunction

  // Drive an instruction into ID and compute its expected group
  task automatic set_instr(input bit vill, input int sew, input int vlmul, input int vlv,
                           input int vd_, input int vs2_, input int vs1_, input bit isvv_);
    int groups;
    valid = 1'b1;
    vtype = {vill, 2'($urandom), 3'(sew), 3'(vlmul)};
    vl    = 8'(vlv);
    vd    = 5'(vd_);
    vs2   = 5'(vs2_);
    vs1   = 5'(vs1_);
    is_vv = isvv_;
    m_vd = vd_; m_vs2 = vs2_; m_vs1 = vs1_; m_isvv = isvv_; m_vl = vlv;
    m_lmul = (vlmul <= 3) ? (1 << vlmul) : 1;
    m_epr  = (sew <= 3) ? (16 >> sew) : 1;
    m_illegal = vill || (sew > 3) || (vlmul == 4) || (vd_ % m_lmul != 0) ||
                (vs2_ % m_lmul != 0) || (isvv_ && (vs1_ % m_lmul != 0));
    groups = (vlv + m_epr - 1) / m_epr;
    m_n = (vlv == 0) ? 1 : ((groups < m_lmul) ? groups : m_lmul);
  endtask

  task automatic check_uop(input int k);
    int base, cnt;
    base = k * m_epr;
    cnt  = (m_vl > base) ? (((m_vl - base) < m_epr) ? (m_vl - base) : m_epr) : 0;
    check($sformatf("valid[%0d]", k), uop_valid, 1);
    check($sformatf("first[%0d]", k), uop_first, (k == 0));
    check($sformatf("last[%0d]", k),  uop_last,  (k == m_n - 1));
    check($sformatf("idx[%0d]", k),   uop_idx,   k);
    check($sformatf("vd[%0d]", k),    vd_uop,    m_vd + k);
    check($sformatf("vs2[%0d]", k),   vs2_uop,   m_vs2 + k);
    check($sformatf("vs1[%0d]", k),   vs1_uop,   m_isvv ? (m_vs1 + k) : m_vs1);
    check($sformatf("base[%0d]", k),  elem_base, base);
    check($sformatf("cnt[%0d]", k),   elem_cnt,  cnt);
    check($sformatf("stall[%0d]", k), seq_stall, (k < m_n - 1));
    check($sformatf("ill[%0d]", k),   illegal,   0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, uop_valid, 0);
    check({tag, "_stall"}, seq_stall, 0);
    check({tag, "_ill"},   illegal,   0);
    check({tag, "_first"}, uop_first, 0);
    check({tag, "_last"},  uop_last,  0);
    check({tag, "_idx"},   uop_idx,   0);
    check({tag, "_regs"},  {vd_uop, vs2_uop, vs1_uop}, 0);
    check({tag, "_elem"},  {elem_base, elem_cnt}, 0);
  endtask

  task automatic check_idle();
    valid = 1'b0;
    @(negedge clk);
    check_zero("idle");
    @(posedge clk); #1;
  endtask

  task automatic check_illegal();
    @(negedge clk);
    check("illegal", illegal, 1);
    check("ill_valid", uop_valid, 0);
    check("ill_stall", seq_stall, 0);
    @(posedge clk); #1;
  endtask

  // Walk one group, optionally holding riscv_stall and scrambling ID/CSR inputs mid-group
  task automatic run_group(input int stall_pct, input int stall_at, input int stall_len,
                           input bit scramble);
    int k, held, guard, stall_seen, stall_exp;
    k = 0; held = 0; guard = 0; stall_seen = 0; stall_exp = 0;
    while (k < m_n) begin
      rstall = 1'b0;
      if (k == stall_at && held < stall_len) begin
        rstall = 1'b1;
        held++;
      end else if (guard < 16 && $urandom_range(99) < stall_pct) begin
        rstall = 1'b1;
        guard++;
      end
      @(negedge clk);
      check_uop(k);
      if (seq_stall) stall_seen++;
      if (k < m_n - 1) stall_exp++;
      @(posedge clk); #1;
      if (!rstall) k++;
      if (scramble && k >= 1 && k < m_n) begin
        vtype = 9'($urandom);
        vl    = 8'($urandom_range(128));
        vd    = 5'($urandom);
      end
    end
    rstall = 1'b0;
    check("stall_cycles", stall_seen, stall_exp);
  endtask

  task automatic run_instr(input int stall_pct, input bit scramble);
    if (m_illegal) check_illegal();
    else run_group(stall_pct, -1, 0, scramble);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; is_vv = 1'b0; rstall = 1'b0; flush = 1'b0;
    vs1 = '0; vs2 = '0; vd = '0; vtype = '0; vl = '0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle();

    // Single micro-op, LMUL=1
    set_instr(0, 0, 0, 16, 3, 0, 0, 0);
    run_group(0, -1, 0, 0);
    // Full LMUL=8 group
    set_instr(0, 0, 3, 128, 8, 16, 24, 1);
    check("n8", m_n, 8);
    run_group(0, -1, 0, 0);
    // Short vl truncates an LMUL=4 group to two micro-ops
    set_instr(0, 2, 2, 6, 4, 8, 12, 1);
    run_group(0, -1, 0, 0);
    // vl=0 still issues one empty micro-op
    set_instr(0, 0, 1, 0, 2, 4, 6, 0);
    run_group(0, -1, 0, 0);

    // Illegal cases: misaligned vd, vill, reserved vlmul
    set_instr(0, 0, 1, 32, 5, 2, 4, 1);
    check_illegal();
    set_instr(1, 0, 0, 16, 1, 2, 3, 0);
    check_illegal();
    set_instr(0, 0, 4, 16, 0, 0, 0, 0);
    check_illegal();
    check_idle();

    // riscv_stall held at idx 2 of an LMUL=4 group
    set_instr(0, 0, 2, 64, 4, 8, 12, 0);
    run_group(0, 2, 3, 0);

    // Flush at idx 1 (with stall asserted too), then a new ID instruction
    set_instr(0, 0, 2, 64, 0, 4, 8, 1);
    @(negedge clk);
    check_uop(0);
    @(posedge clk); #1;
    flush = 1'b1; rstall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rstall = 1'b0;
    set_instr(0, 0, 0, 16, 7, 9, 11, 0);
    run_group(0, -1, 0, 0);
    check_idle();

    // Async reset at idx 3 of an LMUL=8 group
    set_instr(0, 0, 3, 128, 16, 8, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_uop(k);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    #2;
    rst_n = 1'b0; valid = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_instr(0, 1, 1, 16, 2, 4, 6, 1);
    run_group(0, -1, 0, 0);

    // Randomized instructions with random stalls and mid-group CSR churn
    for (int t = 0; t < 120; t++) begin
      int vlm, sew, lm, epr, vlv;
      bit vill_;
      vlm   = $urandom_range(7);
      sew   = ($urandom_range(9) == 0) ? $urandom_range(7, 4) : $urandom_range(3);
      vill_ = ($urandom_range(19) == 0);
      lm    = (vlm <= 3) ? (1 << vlm) : 1;
      epr   = (sew <= 3) ? (16 >> sew) : 1;
      vlv   = ($urandom_range(1) == 1) ? $urandom_range(lm * epr) : $urandom_range(128);
      set_instr(vill_, sew, vlm, vlv, pick_reg(lm), pick_reg(lm), pick_reg(lm),
                1'($urandom_range(1)));
      run_instr(15, 1'b1);
      if ($urandom_range(7) == 0) check_idle();
    end
    check_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
